// File: rtl/sigmoid_pkg.sv
`default_nettype none
// ============================================================================
//  Package : sigmoid_pkg
//  Shared widths, the packer assembly-state enum and the transistor counts
//  of the cells used when reporting `number`.
//  Rev 1.0 : initial release
// ============================================================================
package sigmoid_pkg;

  localparam int LANE_W = 8;    // one sigmoid result byte
  localparam int WORD_W = 32;   // packed output word
  localparam int CNT_W  = 3;    // byte count 0..4 carried with each word
  localparam int NUM_W  = 51;   // width of `number`, shared with the sigmoid stage

  typedef logic [NUM_W-1:0] num_t;

  // Bytes currently held in the assembly register.
  typedef enum logic [1:0] {
    E0 = 2'd0,
    L1 = 2'd1,
    L2 = 2'd2,
    L3 = 2'd3
  } fill_e;

  // Transistor counts per cell. The flip-flop is the plain D cell; reset
  // reaches it through an AND gate in the D path.
  localparam int TC_DFF  = 20;
  localparam int TC_MUX2 = 12;
  localparam int TC_AND2 = 6;
  localparam int TC_OR2  = 6;

endpackage
`default_nettype wire

// File: rtl/packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : packer_fifo
//  DEPTH-entry FIFO of {count, word} entries with wrapping read/write
//  pointers and an occupancy counter that separates full from empty.
//  Ports   : clk, rst            - clock, synchronous active-high reset
//            push_i, word_i,
//            count_i             - entry to append
//            pop_i               - remove head (ignored when empty)
//            word_o, count_o     - head entry, zero when empty
//            valid_o             - FIFO non-empty
//            drop_o              - push refused because full and not popping
//            number              - transistor count of this block
//  Rev 1.0 : initial release
// ============================================================================
module packer_fifo
  import sigmoid_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] word_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              valid_o,
  output logic              drop_o,
  output logic [NUM_W-1:0]  number
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int ENT_W = WORD_W + CNT_W;

  localparam num_t FIFO_NUM = num_t'(
      (DEPTH * ENT_W + 2 * PTR_W + OCC_W) * (TC_DFF + TC_AND2)  // state + reset gating
    + DEPTH * ENT_W * TC_MUX2                                  // write-enable hold mux
    + (DEPTH - 1) * ENT_W * TC_MUX2                            // head read mux
    + ENT_W * TC_AND2                                          // zero head when empty
    + (2 * PTR_W + 2 * OCC_W) * TC_MUX2                        // pointer/occupancy update
    + 4 * TC_AND2 + 2 * TC_OR2);                               // push/pop/drop control

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             empty, full, do_push, do_pop;
  logic [ENT_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_W'(DEPTH));
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (do_push && !do_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else if (do_push && (wr_ptr_q == PTR_W'(i))) begin
        mem_q[i] <= {count_i, word_i};
      end
    end
  end

  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign word_o  = head[WORD_W-1:0];
  assign count_o = head[ENT_W-1:WORD_W];
  assign valid_o = !empty;
  assign number  = FIFO_NUM;

endmodule
`default_nettype wire

// File: rtl/sigmoid_packer.sv
`default_nettype none
// ============================================================================
//  Module  : sigmoid_packer
//  Packs four consecutive sigmoid result bytes into a 32-bit word (first
//  byte in [7:0]) and queues words in a small FIFO. Input is never refused;
//  words lost to a full FIFO set a sticky overflow flag.
//  Ports   : clk, rst            - clock, synchronous active-high reset
//            i_valid, i_y        - result byte and its qualifier
//            i_flush             - commit the partially filled word
//            o_word, o_count,
//            o_valid, i_ready    - FIFO head and valid/ready handshake
//            o_overflow          - sticky word-drop flag
//            number              - transistor count of the block
//  Rev 1.0 : initial release
// ============================================================================
module sigmoid_packer
  import sigmoid_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [LANE_W-1:0] i_y,
  input  logic              i_flush,
  output logic [WORD_W-1:0] o_word,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overflow,
  output logic [NUM_W-1:0]  number
);

  localparam num_t TOP_NUM = num_t'(
      (WORD_W + 2 + 1) * (TC_DFF + TC_AND2)   // assembly, fill, overflow + reset gating
    + LANES * LANE_W * TC_MUX2                // lane write muxes
    + WORD_W * TC_AND2                        // assembly clear on commit
    + 2 * TC_MUX2 + CNT_W * TC_MUX2           // fill next-state and count adder
    + 6 * TC_AND2 + 4 * TC_OR2);              // commit decode, pop, sticky flag

  fill_e             fill_q, fill_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              ovf_q;

  logic [WORD_W-1:0] lane_word;
  logic              commit;
  logic [CNT_W-1:0]  commit_count;
  logic [1:0]        fill_bits;
  logic              pop;
  logic              drop;
  logic [NUM_W-1:0]  fifo_number;

  assign fill_bits = fill_q;

  // Lane k takes the incoming byte when it is the next free lane.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_word[k*LANE_W +: LANE_W] =
      (i_valid && (fill_bits == 2'(k))) ? i_y : asm_q[k*LANE_W +: LANE_W];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= E0;
      asm_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      asm_q  <= asm_d;
      ovf_q  <= ovf_q | drop;
    end
  end

  // Next-state logic
  always_comb begin
    fill_d = fill_q;
    if (commit) begin
      fill_d = E0;
    end else if (i_valid) begin
      fill_d = fill_e'(fill_bits + 2'd1);
    end
  end

  // Output / datapath control. Lanes above the fill point are already zero
  // because the assembly register is cleared on every commit.
  always_comb begin
    commit       = (i_valid && (fill_q == L3)) ||
                   (i_flush && ((fill_q != E0) || i_valid));
    commit_count = {1'b0, fill_bits} + {2'b00, i_valid};
    asm_d        = commit ? '0 : lane_word;
  end

  assign pop = o_valid && i_ready;

  packer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (commit),
    .word_i  (lane_word),
    .count_i (commit_count),
    .pop_i   (pop),
    .word_o  (o_word),
    .count_o (o_count),
    .valid_o (o_valid),
    .drop_o  (drop),
    .number  (fifo_number)
  );

  assign o_overflow = ovf_q;
  assign number     = fifo_number + TOP_NUM;

endmodule
`default_nettype wire
